spi_reg_slave: RTL and testbench

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_reg_slave.sv | 195 +++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_slave_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_slave_pkg;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned NREGS        = 32;
  localparam int unsigned BIT_CNT_W    = 3;
  localparam int unsigned CMD_ADDR_MSB = 7;
  localparam int unsigned CMD_ADDR_LSB = 3;
  localparam int unsigned CMD_WR_BIT   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input with rise/fall detect.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = STAGES'({sync_q, d_i});
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave in front of a 32x8 register file with a fabric host port.
// Define SPI_REG_SLAVE_AUTOINC_EN to auto-increment the address after each data byte.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SCLK_DIV_MIN = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] stat_i,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              reg_wr_pulse,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              xfer_done
);

  // SCLK edge to MISO update takes SYNC_STAGES+1 cycles; that must fit in half an SCLK period.
  if (SCLK_DIV_MIN < 2 * (SYNC_STAGES + 1)) begin : g_div_check
    $error("SCLK_DIV_MIN too small for SYNC_STAGES");
  end

  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk_clk), .rst(reset_reset), .d_i(spi_sclk),
    .q_o(sclk_sync), .rise_c(sclk_rise), .fall_c(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk_clk), .rst(reset_reset), .d_i(spi_mosi),
    .q_o(mosi_sync), .rise_c(mosi_rise), .fall_c(mosi_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk_clk), .rst(reset_reset), .d_i(spi_ss_n),
    .q_o(ss_sync), .rise_c(ss_rise), .fall_c(ss_fall));

  assign unused_sync = ^{sclk_sync, mosi_rise, mosi_fall};

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]      mosi_sr_q, mosi_sr_d;
  logic [DATA_W-1:0]      miso_sr_q, miso_sr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic                   reload_q, reload_d;
  logic                   armed_q, armed_d;
  logic [DATA_W-1:0]      regs_q [NREGS];
  logic [DATA_W-1:0]      regs_d [NREGS];
  logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;
  logic                   reg_wr_pulse_q, reg_wr_pulse_d;
  logic [ADDR_W-1:0]      reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_W-1:0]      reg_wr_data_q, reg_wr_data_d;
  logic                   xfer_done_q, xfer_done_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0]      rx_byte;
  logic                   spi_wr;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      mosi_sr_q      <= '0;
      miso_sr_q      <= '0;
      addr_q         <= '0;
      wr_q           <= 1'b0;
      reload_q       <= 1'b0;
      armed_q        <= 1'b0;
      regs_q         <= '{default: '0};
      host_rdata_q   <= '0;
      reg_wr_pulse_q <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
      xfer_done_q    <= 1'b0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      mosi_sr_q      <= mosi_sr_d;
      miso_sr_q      <= miso_sr_d;
      addr_q         <= addr_d;
      wr_q           <= wr_d;
      reload_q       <= reload_d;
      armed_q        <= armed_d;
      regs_q         <= regs_d;
      host_rdata_q   <= host_rdata_d;
      reg_wr_pulse_q <= reg_wr_pulse_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      xfer_done_q    <= xfer_done_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
    end
  end

  // Armed only once SS_n has been seen high, so a transaction already in flight at reset is ignored.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    mosi_sr_d      = mosi_sr_q;
    miso_sr_d      = miso_sr_q;
    addr_d         = addr_q;
    wr_d           = wr_q;
    reload_d       = reload_q;
    armed_d        = armed_q | ss_sync;
    regs_d         = regs_q;
    reg_wr_pulse_d = 1'b0;
    reg_wr_addr_d  = reg_wr_addr_q;
    reg_wr_data_d  = reg_wr_data_q;
    xfer_done_d    = 1'b0;
    rx_byte        = {mosi_sr_q, mosi_sync};
    spi_wr         = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && ss_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          miso_sr_d = stat_i;
        end
      end
      CMD, DATA: begin
        if (ss_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          reload_d    = 1'b0;
          xfer_done_d = 1'b1;
        end else begin
          if (sclk_rise) begin
            mosi_sr_d = rx_byte[DATA_W-2:0];
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == '1) begin
              reload_d = 1'b1;
              if (state_q == CMD) begin
                addr_d  = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                wr_d    = rx_byte[CMD_WR_BIT];
                state_d = DATA;
              end else begin
                if (wr_q) begin
                  spi_wr         = 1'b1;
                  regs_d[addr_q] = rx_byte;
                  reg_wr_pulse_d = 1'b1;
                  reg_wr_addr_d  = addr_q;
                  reg_wr_data_d  = rx_byte;
                end
`ifdef SPI_REG_SLAVE_AUTOINC_EN
                addr_d = addr_q + ADDR_W'(1);
`endif
              end
            end
          end
          // Next byte is loaded on the fall after a completed byte so its MSB leads the next rise.
          if (sclk_fall) begin
            if (reload_q) begin
              miso_sr_d = wr_q ? '0 : regs_q[addr_q];
              reload_d  = 1'b0;
            end else begin
              miso_sr_d = {miso_sr_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (host_wr_en && !spi_wr) begin
      regs_d[host_addr] = host_wdata;
    end

    host_rdata_d = regs_q[host_addr];
    miso_oe_d    = armed_q & ~ss_sync;
    miso_d       = miso_oe_d & miso_sr_d[DATA_W-1];
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = miso_oe_q;
  assign host_rdata   = host_rdata_q;
  assign reg_wr_pulse = reg_wr_pulse_q;
  assign reg_wr_addr  = reg_wr_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign xfer_done    = xfer_done_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: vector table of single-byte transactions plus corner sequences.
module tb_spi_reg_slave;

  localparam int HALF = 4;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] stat_i;
  logic       host_wr_en;
  logic [4:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       reg_wr_pulse;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       xfer_done;

  spi_reg_slave dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .stat_i(stat_i),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .reg_wr_pulse(reg_wr_pulse), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .xfer_done(xfer_done));

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int done_cnt  = 0;
  logic [4:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  always @(negedge clk_clk) begin
    if (reg_wr_pulse) begin
      pulse_cnt++;
      last_wr_addr = reg_wr_addr;
      last_wr_data = reg_wr_data;
    end
    if (xfer_done) done_cnt++;
  end

  typedef struct {
    logic       pre_wr;
    logic [4:0] pre_addr;
    logic [7:0] pre_data;
    logic [7:0] stat;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_rx0;
    logic [7:0] exp_rx1;
    int         exp_pulses;
    logic [4:0] chk_addr;
    logic [7:0] exp_reg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk_clk);
    host_addr  = a;
    host_wdata = d;
    host_wr_en = 1'b1;
    @(negedge clk_clk);
    host_wr_en = 1'b0;
  endtask

  task automatic host_read(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk_clk);
    host_addr = a;
    @(negedge clk_clk);
    v = host_rdata;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk_clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk_clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                         input int nd, output logic [7:0] r0, output logic [7:0] r1,
                         output logic [7:0] r2);
    r1 = '0;
    r2 = '0;
    spi_ss_n = 1'b0;
    spi_bits(cmd, 8, r0);
    if (nd > 0) spi_bits(d0, 8, r1);
    if (nd > 1) spi_bits(d1, 8, r2);
    repeat (HALF) @(negedge clk_clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_miso"},     32'(spi_miso),     32'h0);
    chk({tag, "_miso_oe"},  32'(spi_miso_oe),  32'h0);
    chk({tag, "_wr_pulse"}, 32'(reg_wr_pulse), 32'h0);
    chk({tag, "_wr_addr"},  32'(reg_wr_addr),  32'h0);
    chk({tag, "_wr_data"},  32'(reg_wr_data),  32'h0);
    chk({tag, "_done"},     32'(xfer_done),    32'h0);
    chk({tag, "_rdata"},    32'(host_rdata),   32'h0);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, v;
    int p0, d0c;
    logic got;

    vecs[0] = '{1'b0, 5'd0, 8'h00, 8'h5A, 8'h52, 8'hA5, 8'h5A, 8'h00, 1, 5'd10, 8'hA5};
    vecs[1] = '{1'b0, 5'd0, 8'h00, 8'h81, 8'h50, 8'h00, 8'h81, 8'hA5, 0, 5'd10, 8'hA5};
    vecs[2] = '{1'b0, 5'd0, 8'h00, 8'hC3, 8'h57, 8'h3C, 8'hC3, 8'h00, 1, 5'd10, 8'h3C};
    vecs[3] = '{1'b1, 5'd3, 8'h3C, 8'h81, 8'h18, 8'h00, 8'h81, 8'h3C, 0, 5'd3,  8'h3C};
    vecs[4] = '{1'b0, 5'd0, 8'h00, 8'hFF, 8'h1D, 8'hAA, 8'hFF, 8'h3C, 0, 5'd3,  8'h3C};
    vecs[5] = '{1'b0, 5'd0, 8'h00, 8'h00, 8'hFA, 8'hFF, 8'h00, 8'h00, 1, 5'd31, 8'hFF};
    vecs[6] = '{1'b0, 5'd0, 8'h00, 8'h12, 8'h02, 8'h80, 8'h12, 8'h00, 1, 5'd0,  8'h80};
    vecs[7] = '{1'b0, 5'd0, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h00, 8'hFF, 0, 5'd31, 8'hFF};

    reset_reset = 1'b1;
    spi_sclk    = 1'b0;
    spi_mosi    = 1'b0;
    spi_ss_n    = 1'b1;
    stat_i      = 8'h00;
    host_wr_en  = 1'b0;
    host_addr   = '0;
    host_wdata  = '0;
    repeat (3) @(negedge clk_clk);
    chk_outs_zero("reset0");
    reset_reset = 1'b0;
    repeat (10) @(negedge clk_clk);
    chk("idle_miso_oe", 32'(spi_miso_oe), 32'h0);
    host_read(5'd10, v);
    chk("reset_reg10", 32'(v), 32'h0);

    // Single-data-byte transactions
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_wr) host_write(vecs[i].pre_addr, vecs[i].pre_data);
      stat_i = vecs[i].stat;
      p0  = pulse_cnt;
      d0c = done_cnt;
      run_txn(vecs[i].cmd, vecs[i].data, 8'h00, 1, r0, r1, r2);
      chk($sformatf("vec%0d_rx_cmd", i), 32'(r0), 32'(vecs[i].exp_rx0));
      chk($sformatf("vec%0d_rx_data", i), 32'(r1), 32'(vecs[i].exp_rx1));
      chk($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - p0), 32'(vecs[i].exp_pulses));
      chk($sformatf("vec%0d_done", i), 32'(done_cnt - d0c), 32'h1);
      if (vecs[i].exp_pulses == 1) begin
        chk($sformatf("vec%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].chk_addr));
        chk($sformatf("vec%0d_wr_data", i), 32'(last_wr_data), 32'(vecs[i].exp_reg));
      end
      host_read(vecs[i].chk_addr, v);
      chk($sformatf("vec%0d_reg", i), 32'(v), 32'(vecs[i].exp_reg));
      chk($sformatf("vec%0d_miso_idle", i), 32'({spi_miso_oe, spi_miso}), 32'h0);
    end

    // Burst write from address 31, then burst read back
    stat_i = 8'h00;
    p0 = pulse_cnt;
    run_txn(8'hFA, 8'h11, 8'h22, 2, r0, r1, r2);
    chk("burst_pulses", 32'(pulse_cnt - p0), 32'h2);
    host_read(5'd31, v);
`ifdef SPI_REG_SLAVE_AUTOINC_EN
    chk("burst_reg31", 32'(v), 32'h11);
    host_read(5'd0, v);
    chk("burst_reg0", 32'(v), 32'h22);
    run_txn(8'hF8, 8'h00, 8'h00, 2, r0, r1, r2);
    chk("burst_rd0", 32'(r1), 32'h11);
    chk("burst_rd1", 32'(r2), 32'h22);
`else
    chk("burst_reg31", 32'(v), 32'h22);
    host_read(5'd0, v);
    chk("burst_reg0", 32'(v), 32'h80);
    run_txn(8'hF8, 8'h00, 8'h00, 2, r0, r1, r2);
    chk("burst_rd0", 32'(r1), 32'h22);
    chk("burst_rd1", 32'(r2), 32'h22);
`endif

    // SS_n raised after 5 data bits: partial byte dropped
    p0  = pulse_cnt;
    d0c = done_cnt;
    spi_ss_n = 1'b0;
    spi_bits(8'h52, 8, r0);
    spi_bits(8'hFF, 5, r1);
    repeat (HALF) @(negedge clk_clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
    chk("abort_pulses", 32'(pulse_cnt - p0), 32'h0);
    chk("abort_done", 32'(done_cnt - d0c), 32'h1);
    chk("abort_miso_oe", 32'(spi_miso_oe), 32'h0);
    host_read(5'd10, v);
    chk("abort_reg10", 32'(v), 32'h3C);
    stat_i = 8'h96;
    run_txn(8'h50, 8'h00, 8'h00, 1, r0, r1, r2);
    chk("abort_next_stat", 32'(r0), 32'h96);
    chk("abort_next_rd", 32'(r1), 32'h3C);

    // Host write held active through the SPI write cycle to address 4
    p0 = pulse_cnt;
    got = 1'b0;
    spi_ss_n = 1'b0;
    spi_bits(8'h22, 8, r0);
    fork
      spi_bits(8'h99, 8, r1);
      begin
        host_addr  = 5'd4;
        host_wdata = 8'h77;
        host_wr_en = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
          @(negedge clk_clk);
          if (reg_wr_pulse) got = 1'b1;
        end
        host_wr_en = 1'b0;
      end
    join
    repeat (HALF) @(negedge clk_clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
    chk("collide_seen", 32'(got), 32'h1);
    chk("collide_pulses", 32'(pulse_cnt - p0), 32'h1);
    host_read(5'd4, v);
    chk("collide_reg4", 32'(v), 32'h99);

    // Reset in the middle of a data byte, released while SS_n is still low
    p0  = pulse_cnt;
    d0c = done_cnt;
    stat_i = 8'hFF;
    spi_ss_n = 1'b0;
    spi_bits(8'h52, 8, r0);
    spi_bits(8'hF0, 4, r1);
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    chk_outs_zero("midrst");
    reset_reset = 1'b0;
    spi_bits(8'h52, 8, r0);
    spi_bits(8'hEE, 8, r1);
    chk("stale_miso_oe", 32'(spi_miso_oe), 32'h0);
    chk("stale_miso_rx", 32'(r0), 32'h0);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk_clk);
    chk("stale_pulses", 32'(pulse_cnt - p0), 32'h0);
    chk("stale_done", 32'(done_cnt - d0c), 32'h0);
    host_read(5'd10, v);
    chk("rst_reg10", 32'(v), 32'h0);
    host_read(5'd4, v);
    chk("rst_reg4", 32'(v), 32'h0);
    stat_i = 8'h5A;
    p0  = pulse_cnt;
    d0c = done_cnt;
    run_txn(8'h52, 8'h01, 8'h00, 1, r0, r1, r2);
    chk("post_rst_stat", 32'(r0), 32'h5A);
    chk("post_rst_pulses", 32'(pulse_cnt - p0), 32'h1);
    chk("post_rst_done", 32'(done_cnt - d0c), 32'h1);
    chk("post_rst_wr_addr", 32'(last_wr_addr), 32'd10);
    chk("post_rst_wr_data", 32'(last_wr_data), 32'h01);
    host_read(5'd10, v);
    chk("post_rst_reg10", 32'(v), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
